// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one shared 2*WIDTH-bit adder stepped over WIDTH cycles,
// with a start/ready/done handshake and a synchronous abort.
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset_L,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [2*WIDTH-1:0] sum;

   // Single shared adder: add the shifted multiplicand when the current multiplier bit is set.
   assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, A};
               mplier_d = B;
               acc_d    = '0;
               count_d  = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               acc_d    = sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + CW'(1);
               if (count_q == LastCount) begin
                  product_d = sum;
                  state_d   = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign ready   = (state_q == StIdle);
   assign done    = (state_q == StDone);
   assign product = product_q;

endmodule
